// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule, one round key per valid/ready transfer
module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         start,
    output logic         busy,
    output logic [127:0] round_key,
    output logic [3:0]   rk_index,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         done
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [0:255][7:0] sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:15][7:0] rcon = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36, 48'h0
    };
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction
    state_t        state_q, state_d;
    logic [127:0]  round_key_q, round_key_d, next_key;
    logic [3:0]    rk_index_q, rk_index_d;
    logic          done_q, done_d;
    logic [31:0]   temp, w0, w1, w2, w3;
    // rcon is indexed by the current round: round i+1 uses Rcon[i+1] = rcon[i]
    always_comb begin
        temp = sub_word({round_key_q[23:0], round_key_q[31:24]}) ^ {rcon[rk_index_q], 24'h0};
        w0 = round_key_q[127:96] ^ temp;
        w1 = round_key_q[95:64] ^ w0;
        w2 = round_key_q[63:32] ^ w1;
        w3 = round_key_q[31:0] ^ w2;
        next_key = {w0, w1, w2, w3};
    end
    always_comb begin
        state_d = state_q;
        round_key_d = round_key_q;
        rk_index_d = rk_index_q;
        done_d = 1'b0;
        if (state_q == IDLE && start) begin
            state_d = RUN;
            round_key_d = key_in;
            rk_index_d = 4'd0;
        end else if (state_q == RUN && rk_ready) begin
            if (rk_index_q == 4'd10) begin
                state_d = IDLE;
                done_d = 1'b1;
            end else begin
                round_key_d = next_key;
                rk_index_d = rk_index_q + 4'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_key_q <= 128'h0;
            rk_index_q <= 4'd0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_key_q <= round_key_d;
            rk_index_q <= rk_index_d;
            done_q <= done_d;
        end
    end
    assign busy = state_q == RUN;
    assign rk_valid = state_q == RUN;
    assign round_key = round_key_q;
    assign rk_index = rk_index_q;
    assign done = done_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: table-driven runs plus corner sequences, scoreboard fed by a GF(2^8) reference model
module tb_aes_key_expand;
    logic         clk, rst, start, rk_ready;
    logic [127:0] key_in;
    logic         busy, rk_valid, done;
    logic [127:0] round_key;
    logic [3:0]   rk_index;

    aes_key_expand dut (
        .clk(clk), .rst(rst), .key_in(key_in), .start(start), .busy(busy),
        .round_key(round_key), .rk_index(rk_index), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .done(done)
    );

    typedef struct packed {logic [3:0] idx; logic [127:0] key;} exp_t;
    typedef struct {logic [127:0] key, k1, k2, k10; int mode;} vec_t;

    localparam logic [127:0] key_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] key_b = 128'h000102030405060708090a0b0c0d0e0f;

    exp_t         sb[$];
    vec_t         vecs[3];
    logic [127:0] got_key[0:15];
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    logic         prev_stall = 1'b0;
    int           n_pass = 0, n_total = 0, cyc = 0, stall_cnt = 0, s4 = 0, mode = 0;
    int           t_start, dc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got hang want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h want %h", name, got, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int i = 1; i < 256; i++) if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_ref(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, a, b, c, d;
        t = {sbox_ref(k[23:16]), sbox_ref(k[15:8]), sbox_ref(k[7:0]), sbox_ref(k[31:24])} ^ {rc, 24'h0};
        a = k[127:96] ^ t;
        b = k[95:64] ^ a;
        c = k[63:32] ^ b;
        d = k[31:0] ^ c;
        return {a, b, c, d};
    endfunction

    task automatic push_sched(input logic [127:0] key);
        logic [127:0] k;
        logic [7:0]   rc;
        k = key;
        rc = 8'h01;
        for (int i = 0; i <= 10; i++) begin
            sb.push_back({4'(i), k});
            k = next_ref(k, rc);
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and checks stalled outputs hold
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_key", round_key, prev_key);
                chk("hold_idx", rk_index, prev_idx);
                chk("hold_valid", rk_valid, 1);
            end
            if (rk_valid && rk_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_empty got idx %0d want no transfer", rk_index);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rk_index", rk_index, e.idx);
                    chk("round_key", round_key, e.key);
                end
                got_key[rk_index] = round_key;
            end
            if (rk_valid && !rk_ready) stall_cnt++;
            prev_stall = rk_valid && !rk_ready;
            prev_key = round_key;
            prev_idx = rk_index;
        end else prev_stall = 1'b0;
    end

    // Ready driver: 0 = always ready, 1 = 3-cycle stall on key 4 plus random stalls, 2 = never ready
    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (mode == 0) rk_ready = 1'b1;
            else if (mode == 2) rk_ready = 1'b0;
            else if (rk_valid && rk_index == 4'd4 && s4 < 3) begin
                rk_ready = 1'b0;
                s4++;
            end else rk_ready = $urandom_range(0, 3) != 0;
        end
    end

    task automatic begin_start(input logic [127:0] k);
        key_in = k;
        start = 1'b1;
        push_sched(k);
    endtask

    task automatic finish_start();
        @(posedge clk);
        #1;
        start = 1'b0;
        t_start = cyc;
        stall_cnt = 0;
        s4 = 0;
        for (int i = 0; i < 16; i++) got_key[i] = 128'h0;
    endtask

    task automatic start_run(input logic [127:0] k);
        begin_start(k);
        finish_start();
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int i = 0; i < 400 && d < 0; i++) begin
            @(negedge clk);
            if (done) d = cyc;
        end
        if (d < 0) begin
            n_total++;
            $display("FAIL done_timeout got none want done pulse");
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, rk_valid, 0);
        chk({tag, "_idx"}, rk_index, 0);
        chk({tag, "_key"}, round_key, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        vecs[0] = '{key_a, 128'ha0fafe1788542cb123a339392a6c7605,
                    128'hf2c295f27a96b9435935807a7359f67f,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0};
        vecs[1] = '{key_a, 128'ha0fafe1788542cb123a339392a6c7605,
                    128'hf2c295f27a96b9435935807a7359f67f,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1};
        vecs[2] = '{128'h0, 128'h62636363626363636263636362636363, 128'h0,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e, 0};
        rst = 1'b1;
        start = 1'b0;
        key_in = 128'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int v = 0; v < 3; v++) begin
            mode = vecs[v].mode;
            start_run(vecs[v].key);
            wait_done(dc);
            chk("latency", dc - t_start, 11 + stall_cnt);
            chk("key1", got_key[1], vecs[v].k1);
            if (vecs[v].k2 != 128'h0) chk("key2", got_key[2], vecs[v].k2);
            chk("key10", got_key[10], vecs[v].k10);
            if (vecs[v].mode == 1) chk("stall_key4", s4, 3);
            @(posedge clk);
            #1;
            chk("idle_busy", busy, 0);
            mode = 0;
        end
        // start pulsed mid-run and held through the final transfer is ignored
        start_run(key_a);
        repeat (3) @(posedge clk);
        #1;
        key_in = key_b;
        start = 1'b1;
        wait_done(dc);
        start = 1'b0;
        chk("ign_latency", dc - t_start, 11);
        chk("ign_key10", got_key[10], vecs[0].k10);
        @(posedge clk);
        #1;
        chk("ign_busy", busy, 0);
        start_run(key_b);
        wait_done(dc);
        chk("keyb_key10", got_key[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        @(posedge clk);
        #1;
        // reset while presenting key 5
        start_run(key_a);
        begin
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < 30 && !hit; i++) begin
                @(posedge clk);
                #1;
                hit = rk_valid && rk_index == 4'd5;
            end
            if (!hit) begin
                n_total++;
                $display("FAIL idx5_timeout got idx %0d want 5", rk_index);
            end
        end
        mode = 2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        chk_reset_vals("midrst");
        mode = 0;
        start_run(key_a);
        wait_done(dc);
        chk("rst_latency", dc - t_start, 11);
        chk("rst_key10", got_key[10], vecs[0].k10);
        // back-to-back: new start accepted in the done cycle
        chk("b2b_busy_done", busy, 0);
        begin_start(key_a);
        finish_start();
        chk("b2b_busy", busy, 1);
        chk("b2b_valid", rk_valid, 1);
        chk("b2b_idx", rk_index, 0);
        chk("b2b_key0", round_key, key_a);
        chk("b2b_done", done, 0);
        wait_done(dc);
        chk("b2b_latency", dc - t_start, 11);
        chk("b2b_key10", got_key[10], vecs[0].k10);
        @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
